// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - Wishbone-fed bitstream loader driving a fabric configuration chain
module ccff_loader #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        prog_clk_o,
    output logic        ccff_head_o,
    input  logic        ccff_tail_i,
    output logic        prog_reset_o,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic          go_q, go_d, abort_q, abort_d;
    logic          prst_q, prst_d, done_q, done_d, ovf_q, ovf_d;
    logic [31:0]   count_q, count_d, remain_q, remain_d;
    logic [31:0]   tail_q, tail_d, shreg_q, shreg_d;
    logic [4:0]    idx_q, idx_d;
    logic [7:0]    div_q, div_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          prog_clk_q, prog_clk_d, head_q, head_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic       req, wr, push, pop, full, empty, busy;
    logic [1:0] addr;
    logic       unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    // Bus decode, register updates, FIFO bookkeeping and the shift FSM
    always_comb begin
        state_d    = state_q;
        dat_d      = 32'd0;
        go_d       = 1'b0;
        abort_d    = 1'b0;
        prst_d     = prst_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        remain_d   = remain_q;
        tail_d     = tail_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        div_d      = div_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        pop        = 1'b0;

        req   = wbs_stb_i & wbs_cyc_i & ~ack_q;
        wr    = req & wbs_we_i;
        addr  = wbs_adr_i[3:2];
        full  = (level_q == LVL_FULL);
        empty = (level_q == '0);
        busy  = (state_q != S_IDLE);
        push  = wr && (addr == 2'd2) && !full;
        ack_d = req;

        if (req && !wbs_we_i) begin
            case (addr)
                2'd0:    dat_d = {29'd0, prst_q, 2'd0};
                2'd1:    dat_d = {19'd0, 5'(level_q), 3'd0, ovf_q, done_q, empty, full, busy};
                2'd2:    dat_d = tail_q;
                default: dat_d = count_q;
            endcase
        end

        if (wr) begin
            case (addr)
                2'd0: begin
                    go_d    = wbs_dat_i[0];
                    abort_d = wbs_dat_i[1];
                    prst_d  = wbs_dat_i[2];
                end
                2'd1: begin
                    if (wbs_dat_i[3]) done_d = 1'b0;
                    if (wbs_dat_i[4]) ovf_d  = 1'b0;
                end
                2'd2:    if (full) ovf_d = 1'b1;
                default: count_d = wbs_dat_i;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (go_q && !abort_q) begin
                    if (count_q != 32'd0) begin
                        state_d  = S_LOAD;
                        remain_d = count_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    idx_d   = 5'd31;
                    div_d   = DIV_LAST;
                    state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (div_q == 8'd0) begin
                    div_d   = DIV_LAST;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            S_SHIFT_HI: begin
                if (div_q == DIV_LAST) tail_d = {tail_q[30:0], ccff_tail_i};
                if (div_q == 8'd0) begin
                    remain_d = remain_q - 32'd1;
                    if (remain_q == 32'd1) begin
                        state_d = S_DONE;
                    end else if (idx_q == 5'd0) begin
                        state_d = S_LOAD;
                    end else begin
                        idx_d   = idx_q - 5'd1;
                        div_d   = DIV_LAST;
                        state_d = S_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            default: begin
                if (!abort_q) done_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        if (abort_q) begin
            state_d  = S_IDLE;
            pop      = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end

        // Outputs are derived from the next state so they leave a flop cleanly
        prog_clk_d = (state_d == S_SHIFT_HI);
        case (state_d)
            S_SHIFT_LO:         head_d = shreg_d[idx_d];
            S_SHIFT_HI, S_LOAD: head_d = head_q;
            default:            head_d = 1'b0;
        endcase
    end

    // State and register flops with synchronous active-low reset
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            go_q       <= 1'b0;
            abort_q    <= 1'b0;
            prst_q     <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= 32'd0;
            remain_q   <= 32'd0;
            tail_q     <= 32'd0;
            shreg_q    <= 32'd0;
            idx_q      <= 5'd0;
            div_q      <= 8'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            prog_clk_q <= 1'b0;
            head_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            go_q       <= go_d;
            abort_q    <= abort_d;
            prst_q     <= prst_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            remain_q   <= remain_d;
            tail_q     <= tail_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            prog_clk_q <= prog_clk_d;
            head_q     <= head_d;
        end
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wbs_dat_i;
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign prog_clk_o   = prog_clk_q;
    assign ccff_head_o  = head_q;
    assign prog_reset_o = prst_q;
    assign irq_o        = done_q;
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving wb_clk_i cycles per prog_clk phase (range 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of 32-bit bitstream words buffered (power of 2, 2..16).
REQ-003 wb_clk_i  input  1  single clock for all logic.
REQ-004 wb_rst_ni  input  1  synchronous, active-low reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone slave strobe, cycle and write-enable.
REQ-006 wbs_adr_i  input  32  byte address; only bits [3:2] decoded.
REQ-007 wbs_dat_i  input  32  write data; wbs_sel_i ignored, all writes are full-word.
REQ-008 wbs_ack_o  output  1  Wishbone acknowledge.
REQ-009 wbs_dat_o  output  32  read data.
REQ-010 prog_clk_o  output  1  configuration-chain clock to the fabric.
REQ-011 ccff_head_o  output  1  serial configuration data into the fabric chain.
REQ-012 ccff_tail_i  input  1  serial data returned from the chain end.
REQ-013 prog_reset_o  output  1  fabric programming reset, software-driven level.
REQ-014 irq_o  output  1  done interrupt, level.

Function
REQ-015 Register map: 0x0 CTRL (W: bit0 GO, bit1 ABORT, bit2 PRST; R: bit2 PRST, others 0); 0x4 STATUS (R: bit0 BUSY, bit1 FULL, bit2 EMPTY, bit3 DONE, bit4 OVF, bits[12:8] level; W1C on bits 3,4); 0x8 DATA (W: FIFO push; R: TAIL capture word); 0xC COUNT (R/W, total bits to shift).
REQ-016 wbs_ack_o SHALL assert exactly one cycle after a cycle with stb&cyc&!ack, then deassert; no wait states; back-to-back accesses ack every other cycle.
REQ-017 Register writes/pushes SHALL take effect in the ack cycle; wbs_dat_o SHALL be valid in the ack cycle and 0 otherwise.
REQ-018 DATA write while FULL SHALL be dropped and set OVF; push and pop in the same cycle SHALL leave level unchanged.
REQ-019 FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
REQ-020 IDLE: GO with COUNT!=0 -> LOAD; GO with COUNT=0 -> DONE; GO while BUSY ignored; BUSY=1 in every state except IDLE.
REQ-021 LOAD: if FIFO empty, stall with prog_clk_o=0; else pop head word into shift register, bit index=31, -> SHIFT_LO (one cycle).
REQ-022 SHIFT_LO: prog_clk_o=0, ccff_head_o=shift-register bit[index] (MSB first), held CLK_DIV cycles, -> SHIFT_HI.
REQ-023 SHIFT_HI: prog_clk_o=1 for CLK_DIV cycles; on entry cycle sample ccff_tail_i into TAIL as {TAIL[30:0],tail}; remaining decremented on exit.
REQ-024 SHIFT_HI exit: remaining=0 -> DONE; else index=0 -> LOAD; else index-1 -> SHIFT_LO.
REQ-025 DONE: set DONE sticky, -> IDLE next cycle; leftover FIFO bits of a partial last word SHALL be discarded.
REQ-026 COUNT SHALL be latched at GO; COUNT writes while BUSY SHALL not affect the running load.
REQ-027 ABORT in any state SHALL go to IDLE next cycle, drive prog_clk_o=0, flush FIFO, not set DONE; ABORT+GO in one write: ABORT wins.
REQ-028 irq_o SHALL equal DONE; writing 1 to STATUS bit3 clears it; set and clear in the same cycle: set wins.
REQ-029 prog_reset_o SHALL follow CTRL.PRST without affecting the FSM.
REQ-030 prog_clk_o and ccff_head_o SHALL be registered outputs, glitch-free.

Reset
REQ-031 On wb_rst_ni=0 at a clock edge: FSM=IDLE, FIFO empty, COUNT=0, TAIL=0, DONE=0, OVF=0, PRST=1.
REQ-032 Reset output values: wbs_ack_o=0, wbs_dat_o=0, prog_clk_o=0, ccff_head_o=0, prog_reset_o=1, irq_o=0.
REQ-033 Reset mid-shift SHALL abandon the transfer with no further prog_clk_o edges.

Verification
REQ-034 Push 0xA5000000, COUNT=8, GO -> ccff_head_o sequence 1,0,1,0,0,1,0,1; 8 prog_clk_o pulses each 4 high/4 low; DONE=1, irq_o=1.
REQ-035 Tail loopback, push 0x12345678 and 0x9ABCDEF0, COUNT=64 -> TAIL reads 0x9ABCDEF0; one extra low cycle between words.
REQ-036 Push 5 words with FIFO_DEPTH=4 -> OVF=1, level=4, fifth word absent from stream.
REQ-037 COUNT=40 with one word pushed -> stall in LOAD after 32 bits with prog_clk_o=0; second push resumes, 8 more pulses, then DONE.
REQ-038 ABORT after 10 bits -> prog_clk_o=0 next cycle, BUSY=0, EMPTY=1, DONE=0.
REQ-039 GO with COUNT=0 -> DONE=1 two cycles after ack, zero prog_clk_o pulses; W1C on bit3 clears irq_o.
